// File: rtl/log_kernel_iter.sv
// log_kernel_iter: iterative ln(1+u) / ln(1-u) series with one shared 8x8 multiplier.
// Optional macro LOG_FIFTH_TERM_EN adds a fifth series term (one extra cycle).
`default_nettype none

module log_kernel_iter (
   input  logic       clk,
   input  logic       rst,
   input  logic       iValid,
   output logic       oReady,
   input  logic [7:0] iData,
   input  logic       iSign,
   output logic       oValid,
   input  logic       iReady,
   output logic [9:0] oData
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_S2   = 3'd1;
   localparam logic [2:0] c_S3   = 3'd2;
   localparam logic [2:0] c_S4   = 3'd3;
`ifdef LOG_FIFTH_TERM_EN
   localparam logic [2:0] c_S5   = 3'd4;
`endif
   localparam logic [2:0] c_OUT  = 3'd5;

   logic [2:0]         r_state;
   logic [2:0]         w_state_next;
   logic [7:0]         r_u;
   logic               r_sign;
   logic [7:0]         r_term;
   logic signed [11:0] r_acc;
   logic [9:0]         r_oData;

   logic [15:0]        w_prod;
   logic [7:0]         w_pk;
   logic [7:0]         w_scaled;
   logic               w_busy;
   logic               w_last;
   logic               w_add;
   logic signed [11:0] w_ext;
   logic signed [11:0] w_acc_next;
   logic [9:0]         w_sat;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: if (iValid) w_state_next = c_S2;
         c_S2:   w_state_next = c_S3;
         c_S3:   w_state_next = c_S4;
`ifdef LOG_FIFTH_TERM_EN
         c_S4:   w_state_next = c_S5;
         c_S5:   w_state_next = c_OUT;
`else
         c_S4:   w_state_next = c_OUT;
`endif
         c_OUT:  if (iReady) w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      oReady = (r_state == c_IDLE);
      oValid = (r_state == c_OUT);
      oData  = r_oData;
   end

   // Shared multiplier: next term is the upper byte of u times the previous term
   assign w_prod = r_u * r_term;
   assign w_pk   = 8'(w_prod >> 8);

   always_comb begin
      w_scaled = 8'd0;
      case (r_state)
         c_S2: w_scaled = w_pk >> 1;
         c_S3: w_scaled = (w_pk >> 2) + (w_pk >> 4);
         c_S4: w_scaled = w_pk >> 2;
`ifdef LOG_FIFTH_TERM_EN
         c_S5: w_scaled = (w_pk >> 2) - (w_pk >> 4);
`endif
         default: w_scaled = 8'd0;
      endcase
   end

`ifdef LOG_FIFTH_TERM_EN
   assign w_busy = (r_state == c_S2) || (r_state == c_S3) ||
                   (r_state == c_S4) || (r_state == c_S5);
   assign w_last = (r_state == c_S5);
   assign w_add  = !r_sign && ((r_state == c_S3) || (r_state == c_S5));
`else
   assign w_busy = (r_state == c_S2) || (r_state == c_S3) || (r_state == c_S4);
   assign w_last = (r_state == c_S4);
   assign w_add  = !r_sign && (r_state == c_S3);
`endif

   // Odd terms add for ln(1+u); every term subtracts for ln(1-u)
   assign w_ext      = $signed({4'b0000, w_scaled});
   assign w_acc_next = w_add ? (r_acc + w_ext) : (r_acc - w_ext);

   always_comb begin
      if (w_acc_next[11] && (w_acc_next[10:9] != 2'b11)) begin
         w_sat = 10'h200;
      end else if (!w_acc_next[11] && (w_acc_next[10:9] != 2'b00)) begin
         w_sat = 10'h1FF;
      end else begin
         w_sat = w_acc_next[9:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_u     <= 8'd0;
         r_sign  <= 1'b0;
         r_term  <= 8'd0;
         r_acc   <= 12'sd0;
         r_oData <= 10'd0;
      end else if ((r_state == c_IDLE) && iValid) begin
         r_u    <= iData;
         r_sign <= iSign;
         r_term <= iData;
         r_acc  <= iSign ? -$signed({4'b0000, iData}) : $signed({4'b0000, iData});
      end else if (w_busy) begin
         r_term <= w_pk;
         r_acc  <= w_acc_next;
         if (w_last) begin
            r_oData <= w_sat;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_log_kernel_iter.sv
// Scoreboard bench for log_kernel_iter: random samples against an arithmetic ln series model,
// plus directed vectors, latency, backpressure and mid-operation reset.
`default_nettype none

module tb_log_kernel_iter;

`ifdef LOG_FIFTH_TERM_EN
   localparam int c_LAT = 5;
`else
   localparam int c_LAT = 4;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       iValid;
   logic       oReady;
   logic [7:0] iData;
   logic       iSign;
   logic       oValid;
   logic       iReady;
   logic [9:0] oData;

   typedef struct {
      logic [9:0] exp;
      logic [7:0] u;
      logic       s;
   } item_t;

   item_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    auto_rdy  = 1'b0;
   bit    fixed_rdy = 1'b0;

   log_kernel_iter dut (
      .clk    (clk),
      .rst    (rst),
      .iValid (iValid),
      .oReady (oReady),
      .iData  (iData),
      .iSign  (iSign),
      .oValid (oValid),
      .iReady (iReady),
      .oData  (oData)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ln(1 +/- u) truncated series, evaluated with plain integer arithmetic
   function automatic logic [9:0] ref_ln(input int u, input bit s);
      int p[1:5];
      int t[2:5];
      int acc;
      logic [31:0] bits;
      p[1] = u;
      for (int k = 2; k <= 5; k++) p[k] = (u * p[k-1]) / 256;
      t[2] = p[2] / 2;
      t[3] = p[3] / 4 + p[3] / 16;
      t[4] = p[4] / 4;
      t[5] = p[5] / 4 - p[5] / 16;
      if (!s) acc = p[1] - t[2] + t[3] - t[4];
      else    acc = -(p[1] + t[2] + t[3] + t[4]);
`ifdef LOG_FIFTH_TERM_EN
      if (!s) acc = acc + t[5];
      else    acc = acc - t[5];
`endif
      if (acc < -512) acc = -512;
      if (acc > 511)  acc = 511;
      bits = acc;
      return bits[9:0];
   endfunction

   // Monitor: drives iReady, pops and compares on every output handshake
   initial begin
      iReady = 1'b0;
      forever begin
         @(negedge clk);
         iReady = auto_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
         if (oValid && iReady) begin
            if (q.size() == 0) begin
               check("unexpected_oValid", 32'd1, 32'd0);
            end else begin
               item_t it;
               it = q.pop_front();
               check($sformatf("result u=%02h s=%0d", it.u, it.s), 32'(oData), 32'(it.exp));
            end
         end
      end
   end

   task automatic send(input logic [7:0] u, input logic s, input logic [9:0] exp);
      int  tries = 0;
      bit  done  = 1'b0;
      @(posedge clk); #1;
      iValid = 1'b1; iData = u; iSign = s;
      while (!done) begin
         @(negedge clk);
         if (oReady) begin
            q.push_back('{exp: exp, u: u, s: s});
            done = 1'b1;
         end else if (++tries > 200) begin
            check("accept_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      iValid = 1'b0;
      iData  = 8'($urandom);
      iSign  = 1'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int n;
      logic [9:0] held;
      rst = 1'b1; iValid = 1'b0; iData = 8'd0; iSign = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_oReady", 32'(oReady), 32'd1);
      check("reset_oValid", 32'(oValid), 32'd0);
      check("reset_oData",  32'(oData),  32'd0);

      // Latency with downstream always ready
      fixed_rdy = 1'b1;
      send(8'h00, 1'b0, 10'h000);
      n = 0;
      while (!oValid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(c_LAT));
      wait_drain();

      // Known-value vectors
`ifdef LOG_FIFTH_TERM_EN
      send(8'h80, 1'b0, 10'h068);
`else
      send(8'h80, 1'b0, 10'h066);
`endif
      send(8'h40, 1'b1, 10'h3B7);
      send(8'hFF, 1'b1, 10'h200);
      wait_drain();

      // Backpressure: result held, new samples ignored
      fixed_rdy = 1'b0;
      send(8'h80, 1'b1, ref_ln(8'h80, 1'b1));
      n = 0;
      while (!oValid && n < 20) begin
         @(negedge clk);
         n++;
      end
      held = oData;
      check("bp_value", 32'(held), 32'(ref_ln(8'h80, 1'b1)));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         iValid = 1'b1; iData = 8'($urandom); iSign = 1'($urandom);
         @(negedge clk);
         check("bp_oValid", 32'(oValid), 32'd1);
         check("bp_oData",  32'(oData),  32'(held));
         check("bp_oReady", 32'(oReady), 32'd0);
      end
      @(posedge clk); #1;
      iValid = 1'b0;
      fixed_rdy = 1'b1;
      wait_drain();

      // Reset while in S3 aborts the sample
      send(8'h55, 1'b0, ref_ln(8'h55, 1'b0));
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      check("rst_oValid", 32'(oValid), 32'd0);
      check("rst_oReady", 32'(oReady), 32'd1);
      check("rst_oData",  32'(oData),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      send(8'h80, 1'b0, ref_ln(8'h80, 1'b0));
      wait_drain();

      // Randomized traffic with random downstream stalls
      auto_rdy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         logic [7:0] u;
         logic       s;
         case ($urandom_range(0, 7))
            0:       u = 8'h00;
            1:       u = 8'hFF;
            default: u = 8'($urandom);
         endcase
         s = 1'($urandom);
         send(u, s, ref_ln(u, s));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      @(posedge clk); #1;
      auto_rdy = 1'b0;
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
